// File: rtl/sockit_spi_stream_arb.sv
// -----------------------------------------------------------------------------
// sockit_spi_stream_arb
//
// Purpose:
//   Shares one SPI serializer stream pair (write stream sdw, read stream sdr)
//   between two requesters. Requester 0 is the register/CPU path and
//   requester 1 is the AXI4 DMA path. A requester books a transfer of L+1
//   words with a length code L. Once granted, that requester owns both
//   streams until L+1 words have been written and L+1 words read.
//
// Configuration macro:
//   SOCKIT_SPI_STREAM_ARB_RR_EN
//     defined   : round-robin arbitration. On simultaneous requests the
//                 requester that did not own the last transfer wins.
//     undefined : fixed priority. Requester 0 wins on simultaneous requests.
//
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   req_x, len_x, gnt_x           transfer booking: level request, length
//                                 code, one-cycle grant pulse (x = 0, 1)
//   sdw_vld_x/sdw_dat_x/sdw_rdy_x requester write streams (into the arbiter)
//   sdr_vld_x/sdr_dat_x/sdr_rdy_x requester read streams (out of the arbiter)
//   sdw_vld/sdw_dat/sdw_rdy       shared write stream towards the serializer
//   sdr_vld/sdr_dat/sdr_rdy       shared read stream from the serializer
//   busy                          a transfer is currently owned
//   owner                         index of the current or last owner
// -----------------------------------------------------------------------------
module sockit_spi_stream_arb #(
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    // requester 0
    input  logic          req_0,
    input  logic [LW-1:0] len_0,
    output logic          gnt_0,
    input  logic          sdw_vld_0,
    input  logic [DW-1:0] sdw_dat_0,
    output logic          sdw_rdy_0,
    output logic          sdr_vld_0,
    output logic [DW-1:0] sdr_dat_0,
    input  logic          sdr_rdy_0,
    // requester 1
    input  logic          req_1,
    input  logic [LW-1:0] len_1,
    output logic          gnt_1,
    input  logic          sdw_vld_1,
    input  logic [DW-1:0] sdw_dat_1,
    output logic          sdw_rdy_1,
    output logic          sdr_vld_1,
    output logic [DW-1:0] sdr_dat_1,
    input  logic          sdr_rdy_1,
    // shared streams
    output logic          sdw_vld,
    output logic [DW-1:0] sdw_dat,
    input  logic          sdw_rdy,
    input  logic          sdr_vld,
    input  logic [DW-1:0] sdr_dat,
    output logic          sdr_rdy,
    // status
    output logic          busy,
    output logic          owner
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          gnt_0_q, gnt_0_d;
    logic          gnt_1_q, gnt_1_d;
    logic [LW-1:0] wcnt_q,  wcnt_d;
    logic [LW-1:0] rcnt_q,  rcnt_d;
    logic          wdone_q, wdone_d;
    logic          rdone_q, rdone_d;

    logic          win;
    logic          w_hs;
    logic          r_hs;
    logic          w_fin;
    logic          r_fin;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef SOCKIT_SPI_STREAM_ARB_RR_EN
    // With both requesting, the one that was not the last owner wins;
    // otherwise the single requester wins.
    assign win = (req_0 && req_1) ? ~owner_q : req_1;
`else
    assign win = ~req_0;
`endif

    // -------------------------------------------------------------------------
    // Stream routing
    // -------------------------------------------------------------------------
    always_comb begin
        sdw_vld   = 1'b0;
        sdw_dat   = owner_q ? sdw_dat_1 : sdw_dat_0;
        sdw_rdy_0 = 1'b0;
        sdw_rdy_1 = 1'b0;
        sdr_vld_0 = 1'b0;
        sdr_vld_1 = 1'b0;
        sdr_dat_0 = sdr_dat;
        sdr_dat_1 = sdr_dat;
        sdr_rdy   = 1'b0;
        if (state_q == XFER) begin
            // A finished direction is closed on both sides so no extra beat
            // can slip through while the other direction is still running.
            if (owner_q) begin
                sdw_vld   = sdw_vld_1 & ~wdone_q;
                sdw_rdy_1 = sdw_rdy   & ~wdone_q;
                sdr_vld_1 = sdr_vld   & ~rdone_q;
                sdr_rdy   = sdr_rdy_1 & ~rdone_q;
            end else begin
                sdw_vld   = sdw_vld_0 & ~wdone_q;
                sdw_rdy_0 = sdw_rdy   & ~wdone_q;
                sdr_vld_0 = sdr_vld   & ~rdone_q;
                sdr_rdy   = sdr_rdy_0 & ~rdone_q;
            end
        end
    end

    // Outputs are already gated by state and done flags.
    assign w_hs  = sdw_vld & sdw_rdy;
    assign r_hs  = sdr_vld & sdr_rdy;
    assign w_fin = wdone_q | (w_hs && (wcnt_q == '0));
    assign r_fin = rdone_q | (r_hs && (rcnt_q == '0));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_0_d = 1'b0;
        gnt_1_d = 1'b0;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wdone_d = wdone_q;
        rdone_d = rdone_q;
        case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    state_d = XFER;
                    owner_d = win;
                    gnt_0_d = ~win;
                    gnt_1_d = win;
                    wcnt_d  = win ? len_1 : len_0;
                    rcnt_d  = win ? len_1 : len_0;
                    wdone_d = 1'b0;
                    rdone_d = 1'b0;
                end
            end
            XFER: begin
                // Counters stop at zero; the final beat raises the done flag.
                if (w_hs && (wcnt_q != '0)) begin
                    wcnt_d = wcnt_q - 1'b1;
                end
                if (r_hs && (rcnt_q != '0)) begin
                    rcnt_d = rcnt_q - 1'b1;
                end
                wdone_d = w_fin;
                rdone_d = r_fin;
                if (w_fin && r_fin) begin
                    state_d = IDLE;
                    wdone_d = 1'b0;
                    rdone_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            gnt_0_q <= 1'b0;
            gnt_1_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_0_q <= gnt_0_d;
            gnt_1_q <= gnt_1_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wdone_q <= wdone_d;
            rdone_q <= rdone_d;
        end
    end

    assign gnt_0 = gnt_0_q;
    assign gnt_1 = gnt_1_q;
    assign busy  = (state_q == XFER);
    assign owner = owner_q;

endmodule

// File: tb/tb_sockit_spi_stream_arb.sv
// -----------------------------------------------------------------------------
// tb_sockit_spi_stream_arb
//
// Directed bench for sockit_spi_stream_arb. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 time unit later, well before the
// next edge.
// -----------------------------------------------------------------------------
module tb_sockit_spi_stream_arb;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          ACLK;
    logic          ARESETn;
    logic          req_0, req_1;
    logic [LW-1:0] len_0, len_1;
    logic          gnt_0, gnt_1;
    logic          sdw_vld_0, sdw_vld_1;
    logic [DW-1:0] sdw_dat_0, sdw_dat_1;
    logic          sdw_rdy_0, sdw_rdy_1;
    logic          sdr_vld_0, sdr_vld_1;
    logic [DW-1:0] sdr_dat_0, sdr_dat_1;
    logic          sdr_rdy_0, sdr_rdy_1;
    logic          sdw_vld;
    logic [DW-1:0] sdw_dat;
    logic          sdw_rdy;
    logic          sdr_vld;
    logic [DW-1:0] sdr_dat;
    logic          sdr_rdy;
    logic          busy;
    logic          owner;

    int total = 0;
    int bad   = 0;

    sockit_spi_stream_arb #(.DW(DW), .LW(LW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_0     (req_0),
        .len_0     (len_0),
        .gnt_0     (gnt_0),
        .sdw_vld_0 (sdw_vld_0),
        .sdw_dat_0 (sdw_dat_0),
        .sdw_rdy_0 (sdw_rdy_0),
        .sdr_vld_0 (sdr_vld_0),
        .sdr_dat_0 (sdr_dat_0),
        .sdr_rdy_0 (sdr_rdy_0),
        .req_1     (req_1),
        .len_1     (len_1),
        .gnt_1     (gnt_1),
        .sdw_vld_1 (sdw_vld_1),
        .sdw_dat_1 (sdw_dat_1),
        .sdw_rdy_1 (sdw_rdy_1),
        .sdr_vld_1 (sdr_vld_1),
        .sdr_dat_1 (sdr_dat_1),
        .sdr_rdy_1 (sdr_rdy_1),
        .sdw_vld   (sdw_vld),
        .sdw_dat   (sdw_dat),
        .sdw_rdy   (sdw_rdy),
        .sdr_vld   (sdr_vld),
        .sdr_dat   (sdr_dat),
        .sdr_rdy   (sdr_rdy),
        .busy      (busy),
        .owner     (owner)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        req_0 = 0; req_1 = 0; len_0 = '0; len_1 = '0;
        sdw_vld_0 = 0; sdw_vld_1 = 0; sdw_dat_0 = '0; sdw_dat_1 = '0;
        sdr_rdy_0 = 0; sdr_rdy_1 = 0;
        sdw_rdy = 0; sdr_vld = 0; sdr_dat = '0;
    endtask

    // Books a transfer for requester 'who' and runs it to completion. Both
    // requesters drive valid write data and ready read streams every cycle;
    // the shared side is throttled by 'toggle' and 'rd_start'.
    task automatic xfer(input bit who, input int len, input int rd_start, input bit toggle);
        int wn = 0;
        int rn = 0;
        int cyc = 0;
        logic [DW-1:0] wbase;
        wbase = who ? 32'h1100_0000 : 32'h0A00_0000;
        if (who) begin req_1 = 1; len_1 = LW'(len); end
        else     begin req_0 = 1; len_0 = LW'(len); end
        tick();
        chk($sformatf("gnt_%0d", who), who ? gnt_1 : gnt_0, 1);
        chk("gnt_other", who ? gnt_0 : gnt_1, 0);
        chk("owner_at_gnt", owner, who);
        chk("busy_at_gnt", busy, 1);
        req_0 = 0; req_1 = 0;
        while ((wn <= len || rn <= len) && cyc < 3000) begin
            sdw_vld_0 = 1; sdw_vld_1 = 1;
            sdr_rdy_0 = 1; sdr_rdy_1 = 1;
            sdw_dat_0 = 32'h0A00_0000 + wn;
            sdw_dat_1 = 32'h1100_0000 + wn;
            sdw_rdy = toggle ? cyc[0] : 1'b1;
            sdr_vld = (cyc >= rd_start) && (toggle ? ~cyc[0] : 1'b1);
            sdr_dat = 32'hB000_0000 + rn;
            #1;
            if (busy !== 1'b1) begin
                chk("busy_during", busy, 1);
                break;
            end
            chk("rdy_own", who ? sdw_rdy_1 : sdw_rdy_0, sdw_rdy && (wn <= len));
            chk("vld_own", who ? sdr_vld_1 : sdr_vld_0, sdr_vld && (rn <= len));
            chk("rdy_other", who ? sdw_rdy_0 : sdw_rdy_1, 0);
            chk("vld_other", who ? sdr_vld_0 : sdr_vld_1, 0);
            if (wn > len) chk("sdw_vld_after_done", sdw_vld, 0);
            if (sdw_vld && sdw_rdy) begin
                chk("sdw_dat", sdw_dat, wbase + wn);
                wn++;
            end
            if (sdr_vld && sdr_rdy) begin
                chk("sdr_dat", who ? sdr_dat_1 : sdr_dat_0, 32'hB000_0000 + rn);
                rn++;
            end
            tick();
            cyc++;
        end
        chk("budget", cyc < 3000, 1);
        chk("wr_words", wn, len + 1);
        chk("rd_words", rn, len + 1);
        chk("busy_after", busy, 0);
        // Everything still offered: nothing may be accepted now.
        sdw_rdy = 1; sdr_vld = 1;
        #1;
        chk("no_extra_w", sdw_vld, 0);
        chk("no_extra_r", sdr_rdy, 0);
        $display("xfer who=%0d len=%0d wr=%0d rd=%0d cycles=%0d", who, len, wn, rn, cyc);
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        ARESETn = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 1);
        chk("rst_gnt0", gnt_0, 0);
        chk("rst_gnt1", gnt_1, 0);
        chk("rst_sdw_vld", sdw_vld, 0);
        chk("rst_sdr_rdy", sdr_rdy, 0);
        $display("reset checked");
        @(negedge ACLK);
        ARESETn = 1;
        tick();

        // basic 4-word transfer for requester 0
        xfer(0, 3, 0, 0);

        // owner 1, requester 0 keeps pushing
        xfer(1, 2, 0, 0);

        // writes finish early, reads held off
        xfer(0, 1, 10, 0);

        // full length with throttled shared streams
        xfer(1, 255, 0, 1);

        // arbitration order from reset
        ARESETn = 0;
        #1;
        ARESETn = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            int expw;
`ifdef SOCKIT_SPI_STREAM_ARB_RR_EN
            expw = k % 2;
`else
            expw = 0;
`endif
            req_0 = 1; req_1 = 1; len_0 = '0; len_1 = '0;
            tick();
            chk("arb_gnt0", gnt_0, expw == 0);
            chk("arb_gnt1", gnt_1, expw == 1);
            chk("arb_owner", owner, expw);
            req_0 = 0; req_1 = 0;
            sdw_vld_0 = 1; sdw_vld_1 = 1; sdr_rdy_0 = 1; sdr_rdy_1 = 1;
            sdw_rdy = 1; sdr_vld = 1;
            tick();
            chk("arb_busy_after", busy, 0);
            $display("arb round=%0d expected winner=%0d owner=%0d", k, expw, owner);
            idle_inputs();
        end

        // reset in the middle of a 10-word transfer
        req_0 = 1; len_0 = 8'd9;
        tick();
        chk("mid_gnt0", gnt_0, 1);
        req_0 = 0;
        sdw_vld_0 = 1; sdr_rdy_0 = 1; sdw_rdy = 1; sdr_vld = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy", busy, 1);
        ARESETn = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_gnt0", gnt_0, 0);
        chk("ar_sdw_rdy0", sdw_rdy_0, 0);
        chk("ar_sdr_vld0", sdr_vld_0, 0);
        chk("ar_sdw_vld", sdw_vld, 0);
        chk("ar_sdr_rdy", sdr_rdy, 0);
        chk("ar_owner", owner, 1);
        $display("async reset mid-transfer checked");
        idle_inputs();
        @(negedge ACLK);
        ARESETn = 1;
        tick();
        xfer(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sockit_spi_stream_arb.md
Name: sockit_spi_stream_arb

Overview:
- Shares the single SPI data stream pair between two requesters: the stream data write channel (sdw) and the stream data read channel (sdr).
- Requester 0 is the register/CPU path; requester 1 is the AXI4 DMA path.
- Each requester books a transfer of N words. The arbiter grants one requester and routes both streams to it until N words have been written and N words read, then releases.
- Sits between the requester stream ports and the SPI serializer stream ports.

Parameters:
DW, 32, stream data width in bits
LW, 8, transfer length field width; a length code L means L+1 words (1..2^LW)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_0  in  1  requester 0 transfer request, level, held until gnt_0
len_0  in  LW  requester 0 length code, valid while req_0
gnt_0  out  1  one-cycle grant/accept pulse to requester 0
sdw_vld_0  in  1  requester 0 write stream valid
sdw_dat_0  in  DW  requester 0 write stream data
sdw_rdy_0  out  1  requester 0 write stream ready
sdr_vld_0  out  1  requester 0 read stream valid
sdr_dat_0  out  DW  requester 0 read stream data
sdr_rdy_0  in  1  requester 0 read stream ready
req_1, len_1, gnt_1, sdw_vld_1, sdw_dat_1, sdw_rdy_1, sdr_vld_1, sdr_dat_1, sdr_rdy_1: same as requester 0, for requester 1
sdw_vld  out  1  shared write stream valid
sdw_dat  out  DW  shared write stream data
sdw_rdy  in  1  shared write stream ready
sdr_vld  in  1  shared read stream valid
sdr_dat  in  DW  shared read stream data
sdr_rdy  out  1  shared read stream ready
busy  out  1  a transfer is owned
owner  out  1  index of the current or last owner

Behaviour:
- Reset values: state IDLE, busy=0, owner=1 (requester 0 wins first under round-robin), gnt_0=gnt_1=0, wcnt=rcnt=0. Reset acts asynchronously in any state and aborts any in-flight transfer; no words are counted after reset.
- States are IDLE and XFER.
- IDLE:
  - No routing: all rdy outputs 0, sdw_vld=0, sdr_vld_0=sdr_vld_1=0, sdr_rdy=0.
  - If any req is high, pick a winner (see arbitration). Next cycle: gnt_winner=1 for exactly one cycle, owner=winner, wcnt=rcnt=len_winner (zero-extended, LW bits), busy=1, state XFER.
- XFER:
  - Owner's streams connect combinationally to the shared streams: sdw_vld=sdw_vld_owner, sdw_dat=sdw_dat_owner, sdw_rdy_owner=sdw_rdy & ~wdone. sdr_vld_owner=sdr_vld & ~rdone, sdr_dat_owner=sdr_dat, sdr_rdy=sdr_rdy_owner & ~rdone.
  - Non-owner: rdy=0, vld=0. Its sdr data outputs mirror sdr_dat (don't-care).
  - Write handshake (sdw_vld & sdw_rdy & ~wdone): if wcnt==0, set wdone; else wcnt-=1. rdone works the same way on the read handshake and rcnt.
  - wdone gates sdw_vld to 0.
  - Write and read handshakes in the same cycle are both counted.
  - When wdone & rdone, go to IDLE next cycle: busy=0; owner holds its value; done flags clear.
  - req inputs are ignored during XFER.
- Latency: request to gnt is 1 cycle. First routed beat can occur in the gnt cycle. There is a minimum 1 IDLE cycle between transfers.
- Length: code 0 = 1 word; 2^LW-1 = 2^LW words. No wrap: counters stop at 0 and use the done flag.
- Arbitration: round-robin; the requester that is not the last owner has priority. With a single request, that requester wins. With simultaneous requests, ~owner wins.

Optional Feature:
- Macro SOCKIT_SPI_STREAM_ARB_RR_EN.
- Defined: round-robin as described under Behaviour.
- Undefined: fixed priority, requester 0 always wins on simultaneous requests. owner still reports the last owner; its reset value is 1.

Test Plan:
- Reset, then req_0=1 with len_0=3 → gnt_0 pulse 1 cycle later, owner=0, busy=1. Exactly 4 sdw and 4 sdr words pass, data identical end to end. busy=0 one cycle after the 4th of both.
- req_0 and req_1 both high with len=0, repeated 4 times after reset (feature on) → grant order 0,1,0,1. Feature off → 0,0,0,0 while both are held.
- Owner 1 with len_1=2; requester 0 drives sdw_vld_0=1 throughout → sdw_rdy_0 stays 0, sdr_vld_0 stays 0, shared stream carries only requester 1 data.
- len=1; writes complete at cycle 3, reads delayed by holding sdr_vld=0 until cycle 10 → sdw_vld=0 after the 2nd write; busy stays 1 until the 2nd read handshake completes.
- len=255, shared rdy toggling 50% → exactly 256 words each direction; no extra beat accepted after the last.
- ARESETn pulsed low mid-transfer (after 5 of 10 words) → all rdy/vld/gnt/busy go 0 immediately. Next req with len=0 transfers exactly 1 word.
